// File: rtl/bus_master.sv
`default_nettype none
// ============================================================================
// Module   : bus_master
// Brief    : 6502-style bus initiator with Phi2 generation, a one-entry
//            command buffer, read responses and a synchronized NMI latch.
// Revision : 1.0 - initial release
// ============================================================================
module bus_master #(
    parameter int HALF_PERIOD = 25
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic        CmdWrite,
    input  logic [15:0] CmdAddr,
    input  logic [7:0]  CmdData,
    output logic        RspValid,
    output logic [7:0]  RspData,
    output logic        Phi2,
    output logic        RW_n,
    output logic [15:0] AddrPhys,
    output logic [7:0]  DataOut,
    output logic        DataOE,
    input  logic [7:0]  DataIn,
    input  logic        NMI_n,
    output logic        NmiPending,
    input  logic        NmiClear,
    output logic [7:0]  NmiCount
);

    localparam int               c_CNT_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HALF_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               phi2_q, phi2_d;

    logic               pend_q, pend_d;
    logic               pend_write_q, pend_write_d;
    logic [15:0]        pend_addr_q, pend_addr_d;
    logic [7:0]         pend_data_q, pend_data_d;

    logic               rw_n_q, rw_n_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         dout_q, dout_d;
    logic               oe_q, oe_d;
    logic               cur_read_q, cur_read_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;

    logic               sync1_q, sync2_q, sync3_q;
    logic               nmi_pend_q, nmi_pend_d;
    logic [7:0]         nmi_cnt_q, nmi_cnt_d;

    logic               w_phase_end;
    logic               w_rise;
    logic               w_fall;
    logic               w_accept;
    logic               w_nmi_set;

    assign w_phase_end = (cnt_q == c_CNT_LAST);
    assign w_rise      = w_phase_end && !phi2_q;
    assign w_fall      = w_phase_end &&  phi2_q;
    assign w_accept    = CmdValid && !pend_q;
    assign w_nmi_set   = sync3_q && !sync2_q;

    always_comb begin
        cnt_d        = w_phase_end ? '0 : (cnt_q + c_CNT_ONE);
        phi2_d       = w_phase_end ? !phi2_q : phi2_q;

        pend_d       = pend_q;
        pend_write_d = pend_write_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;

        rw_n_d       = rw_n_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        oe_d         = oe_q;
        cur_read_d   = cur_read_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;

        // A fall with the buffer full never coincides with an accept, since
        // CmdReady is low then; the two updates of pend_d are exclusive.
        if (w_accept) begin
            pend_d       = 1'b1;
            pend_write_d = CmdWrite;
            pend_addr_d  = CmdAddr;
            pend_data_d  = CmdData;
        end else if (w_fall) begin
            pend_d       = 1'b0;
        end

        if (w_fall) begin
            if (cur_read_q) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = DataIn;
            end
            oe_d = 1'b0;
            if (pend_q) begin
                addr_d     = pend_addr_q;
                rw_n_d     = !pend_write_q;
                dout_d     = pend_data_q;
                cur_read_d = !pend_write_q;
            end else begin
                rw_n_d     = 1'b1;
                cur_read_d = 1'b0;
            end
        end else if (w_rise) begin
            oe_d = !rw_n_q;
        end

        // A new falling edge takes priority over a simultaneous clear.
        if (w_nmi_set) begin
            nmi_pend_d = 1'b1;
        end else if (NmiClear) begin
            nmi_pend_d = 1'b0;
        end else begin
            nmi_pend_d = nmi_pend_q;
        end
        nmi_cnt_d = nmi_cnt_q + {7'd0, w_nmi_set};
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q        <= '0;
            phi2_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_write_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            rw_n_q       <= 1'b1;
            addr_q       <= '0;
            dout_q       <= '0;
            oe_q         <= 1'b0;
            cur_read_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            sync3_q      <= 1'b1;
            nmi_pend_q   <= 1'b0;
            nmi_cnt_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            phi2_q       <= phi2_d;
            pend_q       <= pend_d;
            pend_write_q <= pend_write_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            rw_n_q       <= rw_n_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            oe_q         <= oe_d;
            cur_read_q   <= cur_read_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            sync1_q      <= NMI_n;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            nmi_pend_q   <= nmi_pend_d;
            nmi_cnt_q    <= nmi_cnt_d;
        end
    end

    assign CmdReady   = !pend_q;
    assign RspValid   = rsp_valid_q;
    assign RspData    = rsp_data_q;
    assign Phi2       = phi2_q;
    assign RW_n       = rw_n_q;
    assign AddrPhys   = addr_q;
    assign DataOut    = dout_q;
    assign DataOE     = oe_q;
    assign NmiPending = nmi_pend_q;
    assign NmiCount   = nmi_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_master
// Brief    : Self-checking bench for bus_master against an edge-indexed
//            transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bus_master;

    localparam int HP = 4;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        CmdValid = 1'b0;
    logic        CmdReady;
    logic        CmdWrite = 1'b0;
    logic [15:0] CmdAddr = '0;
    logic [7:0]  CmdData = '0;
    logic        RspValid;
    logic [7:0]  RspData;
    logic        Phi2;
    logic        RW_n;
    logic [15:0] AddrPhys;
    logic [7:0]  DataOut;
    logic        DataOE;
    logic [7:0]  DataIn = '0;
    logic        NMI_n = 1'b1;
    logic        NmiPending;
    logic        NmiClear = 1'b0;
    logic [7:0]  NmiCount;

    always #5 Clock = ~Clock;

    bus_master #(.HALF_PERIOD(HP)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .CmdValid   (CmdValid),
        .CmdReady   (CmdReady),
        .CmdWrite   (CmdWrite),
        .CmdAddr    (CmdAddr),
        .CmdData    (CmdData),
        .RspValid   (RspValid),
        .RspData    (RspData),
        .Phi2       (Phi2),
        .RW_n       (RW_n),
        .AddrPhys   (AddrPhys),
        .DataOut    (DataOut),
        .DataOE     (DataOE),
        .DataIn     (DataIn),
        .NMI_n      (NMI_n),
        .NmiPending (NmiPending),
        .NmiClear   (NmiClear),
        .NmiCount   (NmiCount)
    );

    typedef struct packed {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
    } cmd_t;

    int total = 0;
    int bad   = 0;

    // Model state: edges since reset release, queued command, current bus view.
    cmd_t        pendq[$];
    int          m_n;
    bit          m_acc;
    logic        m_rw, m_oe, m_cur_read, m_rspv, m_nmip;
    logic [15:0] m_addr;
    logic [7:0]  m_dout, m_rspd, m_nmic;
    logic [2:0]  m_hist;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_phi2();
        return ((m_n / HP) % 2) == 1;
    endfunction

    task automatic model_reset();
        pendq.delete();
        m_n = 0; m_acc = 0;
        m_rw = 1'b1; m_oe = 1'b0; m_cur_read = 1'b0; m_rspv = 1'b0; m_nmip = 1'b0;
        m_addr = '0; m_dout = '0; m_rspd = '0; m_nmic = '0;
        m_hist = 3'b111;
    endtask

    task automatic model_edge();
        bit   fall, rise;
        cmd_t c;
        m_n++;
        m_acc = CmdValid && (pendq.size() == 0);
        fall  = (m_n % (2 * HP)) == 0;
        rise  = ((m_n % HP) == 0) && !fall;
        m_rspv = 1'b0;
        if (fall) begin
            if (m_cur_read) begin
                m_rspv = 1'b1;
                m_rspd = DataIn;
            end
            m_oe = 1'b0;
            if (pendq.size() > 0) begin
                c = pendq.pop_front();
                m_addr = c.a; m_rw = !c.w; m_dout = c.d; m_cur_read = !c.w;
            end else begin
                m_rw = 1'b1; m_cur_read = 1'b0;
            end
        end
        if (rise) m_oe = !m_rw;
        if (m_acc) begin
            c.w = CmdWrite; c.a = CmdAddr; c.d = CmdData;
            pendq.push_back(c);
        end
        // m_hist[k] holds NMI_n as sampled k+1 edges ago.
        if (!m_hist[1] && m_hist[2]) begin
            m_nmip = 1'b1;
            m_nmic = m_nmic + 8'd1;
        end else if (NmiClear) begin
            m_nmip = 1'b0;
        end
        m_hist = {m_hist[1:0], NMI_n};
    endtask

    task automatic check_all();
        chk("Phi2",       {31'd0, Phi2},       {31'd0, m_phi2()});
        chk("RW_n",       {31'd0, RW_n},       {31'd0, m_rw});
        chk("AddrPhys",   {16'd0, AddrPhys},   {16'd0, m_addr});
        chk("DataOut",    {24'd0, DataOut},    {24'd0, m_dout});
        chk("DataOE",     {31'd0, DataOE},     {31'd0, m_oe});
        chk("CmdReady",   {31'd0, CmdReady},   {31'd0, pendq.size() == 0});
        chk("RspValid",   {31'd0, RspValid},   {31'd0, m_rspv});
        chk("RspData",    {24'd0, RspData},    {24'd0, m_rspd});
        chk("NmiPending", {31'd0, NmiPending}, {31'd0, m_nmip});
        chk("NmiCount",   {24'd0, NmiCount},   {24'd0, m_nmic});
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic tick_to(input int edge_n);
        while (m_n < edge_n) tick();
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d);
        bit done = 0;
        CmdValid = 1'b1; CmdWrite = w; CmdAddr = a; CmdData = d;
        for (int i = 0; i < 4 * HP && !done; i++) begin
            tick();
            done = m_acc;
        end
        chk("send_accept", {31'd0, done}, 32'd1);
        CmdValid = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] idle_addr;
        bit          found;

        model_reset();
        repeat (3) @(negedge Clock);
        check_all();
        release_reset();

        // First write: accepted at edge 2, on the bus from edge 8.
        DataIn = 8'h5A;
        tick();
        send(1'b1, 16'h8001, 8'h00);
        chk("tp_accept_edge", m_n, 2);
        tick_to(HP);
        chk("tp_first_rise", {31'd0, Phi2}, 32'd1);
        tick_to(8);
        chk("tp_w1_addr", {16'd0, AddrPhys}, 32'h8001);
        chk("tp_w1_rw", {31'd0, RW_n}, 32'd0);
        chk("tp_w1_oe_low", {31'd0, DataOE}, 32'd0);
        tick_to(12);
        chk("tp_w1_oe", {31'd0, DataOE}, 32'd1);
        chk("tp_w1_data", {24'd0, DataOut}, 32'h00);
        tick_to(16);
        chk("tp_w1_rw_end", {31'd0, RW_n}, 32'd1);
        chk("tp_w1_oe_end", {31'd0, DataOE}, 32'd0);

        // Back-to-back write then read.
        send(1'b1, 16'h80A0, 8'h04);
        send(1'b0, 16'h1234, 8'h00);
        chk("tp_rd_accept_edge", m_n, 25);
        tick_to(32);
        chk("tp_rd_addr", {16'd0, AddrPhys}, 32'h1234);
        chk("tp_rd_rw", {31'd0, RW_n}, 32'd1);
        tick_to(40);
        chk("tp_rsp_valid", {31'd0, RspValid}, 32'd1);
        chk("tp_rsp_data", {24'd0, RspData}, 32'h5A);
        tick();
        chk("tp_rsp_pulse", {31'd0, RspValid}, 32'd0);

        // NMI held low: one set, no retrigger.
        NMI_n = 1'b0;
        repeat (3) tick();
        chk("tp_nmi_pend", {31'd0, NmiPending}, 32'd1);
        chk("tp_nmi_cnt", {24'd0, NmiCount}, 32'd1);
        repeat (17) tick();
        chk("tp_nmi_noretrig", {24'd0, NmiCount}, 32'd1);
        NMI_n = 1'b1;
        repeat (4) tick();
        NmiClear = 1'b1;
        tick();
        NmiClear = 1'b0;
        chk("tp_nmi_clear", {31'd0, NmiPending}, 32'd0);
        NMI_n = 1'b0;
        repeat (2) tick();
        NmiClear = 1'b1;
        tick();
        NmiClear = 1'b0;
        chk("tp_nmi_set_wins", {31'd0, NmiPending}, 32'd1);
        chk("tp_nmi_cnt2", {24'd0, NmiCount}, 32'd2);
        NMI_n = 1'b1;
        repeat (3) tick();

        // Ten idle periods.
        idle_addr = m_addr;
        for (int i = 0; i < 10 * 2 * HP; i++) begin
            DataIn = 8'($urandom);
            tick();
            if ((i % HP) == 0) begin
                chk("idle_rw", {31'd0, RW_n}, 32'd1);
                chk("idle_addr", {16'd0, AddrPhys}, {16'd0, idle_addr});
                chk("idle_oe", {31'd0, DataOE}, 32'd0);
                chk("idle_rsp", {31'd0, RspValid}, 32'd0);
            end
        end

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            CmdValid = ($urandom_range(0, 1) == 1);
            CmdWrite = ($urandom_range(0, 1) == 1);
            CmdAddr  = 16'($urandom);
            CmdData  = 8'($urandom);
            DataIn   = 8'($urandom);
            if ($urandom_range(0, 5) == 0) NMI_n = ~NMI_n;
            NmiClear = ($urandom_range(0, 9) == 0);
            tick();
        end
        CmdValid = 1'b0; NmiClear = 1'b0; NMI_n = 1'b1;
        tick_to(((m_n / (2 * HP)) + 1) * 2 * HP);

        // Reset during the high phase of a write, with another command queued.
        send(1'b1, 16'($urandom), 8'($urandom));
        CmdValid = 1'b1; CmdWrite = 1'b0; CmdAddr = 16'hBEEF;
        found = 0;
        for (int i = 0; i < 6 * HP && !found; i++) begin
            tick();
            found = (m_rw == 1'b0) && m_oe && (pendq.size() > 0);
        end
        chk("rst_setup", {31'd0, found}, 32'd1);
        chk("rst_pre_oe", {31'd0, DataOE}, 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        CmdValid = 1'b0;
        release_reset();
        tick_to(2 * HP);
        chk("rst_first_fall", {31'd0, Phi2}, 32'd0);
        chk("rst_idle", {31'd0, RW_n}, 32'd1);
        repeat (4 * HP) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
